// File: rtl/event_deserializer.sv
// Byte-serial to parallel DVS event assembler: collects 7-byte frames into
// an x/y/t/p tuple held in a one-entry valid/ready output register.
module event_deserializer #(
  parameter logic [6:0] MARKER = 7'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] t,
  output logic        p,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [7:0]  err_cnt
);

  logic [2:0]  idx_q, idx_d;
  logic [47:0] staging_q, staging_d;
  logic [15:0] x_q, x_d, y_q, y_d, t_q, t_d;
  logic        p_q, p_d;
  logic        ev_valid_q, ev_valid_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        accept;
  logic        err_inc;

  // Only a flags byte can be stalled; an sof byte at idx 6 starts a new frame.
  always_comb begin
    in_ready = !((idx_q == 3'd6) && ev_valid_q && !ev_ready && !in_sof);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    idx_d      = idx_q;
    staging_d  = staging_q;
    x_d        = x_q;
    y_d        = y_q;
    t_d        = t_q;
    p_d        = p_q;
    ev_valid_d = ev_valid_q;
    err_inc    = 1'b0;

    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_sof) begin
        staging_d[47:40] = in_data;
        idx_d            = 3'd1;
        err_inc          = (idx_q != 3'd0);
      end else if (idx_q == 3'd6) begin
        idx_d = 3'd0;
        if (in_data[7:1] == MARKER) begin
          x_d        = staging_q[47:32];
          y_d        = staging_q[31:16];
          t_d        = staging_q[15:0];
          p_d        = in_data[0];
          ev_valid_d = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
      end else begin
        for (int i = 0; i < 6; i++) begin
          if (idx_q == 3'(i)) begin
            staging_d[47-8*i -: 8] = in_data;
          end
        end
        idx_d = idx_q + 3'd1;
      end
    end

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= 3'd0;
      staging_q  <= 48'd0;
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      t_q        <= 16'd0;
      p_q        <= 1'b0;
      ev_valid_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      idx_q      <= idx_d;
      staging_q  <= staging_d;
      x_q        <= x_d;
      y_q        <= y_d;
      t_q        <= t_d;
      p_q        <= p_d;
      ev_valid_q <= ev_valid_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign t        = t_q;
  assign p        = p_q;
  assign ev_valid = ev_valid_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_event_deserializer.sv
// Directed bench for event_deserializer: framing, back-pressure, sof
// resynchronisation, error saturation and mid-frame reset.
module tb_event_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y, t;
  logic        p;
  logic        ev_valid;
  logic        ev_ready;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  event_deserializer dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .t        (t),
    .p        (p),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .err_cnt  (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is taken.
  task automatic send_byte(input logic [7:0] d, input logic sof);
    int n = 0;
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("byte_accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] fx, input logic [15:0] fy,
                            input logic [15:0] ft, input logic [7:0] flags);
    send_byte(fx[15:8], 1'b0);
    send_byte(fx[7:0],  1'b0);
    send_byte(fy[15:8], 1'b0);
    send_byte(fy[7:0],  1'b0);
    send_byte(ft[15:8], 1'b0);
    send_byte(ft[7:0],  1'b0);
    send_byte(flags,    1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = 8'h00;
    in_sof   = 1'b0;
    in_valid = 1'b0;
    ev_ready = 1'b1;
    idle(3);
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_err_cnt",  32'(err_cnt),  32'd0);
    check("rst_xyt",      {x, y}, 32'd0);
    check("rst_t_p",      {15'd0, t, p}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    idle(2);

    // Basic good frame
    send_frame(16'h1234, 16'h5678, 16'h9ABC, 8'hAB);
    check("f1_ev_valid", 32'(ev_valid), 32'd1);
    check("f1_x", 32'(x), 32'h1234);
    check("f1_y", 32'(y), 32'h5678);
    check("f1_t", 32'(t), 32'h9ABC);
    check("f1_p", 32'(p), 32'd1);
    check("f1_err", 32'(err_cnt), 32'd0);
    idle(1);
    check("f1_consumed", 32'(ev_valid), 32'd0);

    // Bad marker (flags[7:1] = 0x15) then good frame with p=0 (0xAA is a valid marker)
    send_frame(16'h1234, 16'h5678, 16'h9ABC, 8'h2A);
    check("bad_ev_valid", 32'(ev_valid), 32'd0);
    check("bad_err", 32'(err_cnt), 32'd1);
    check("bad_x_kept", 32'(x), 32'h1234);
    send_frame(16'h1122, 16'h3344, 16'h5566, 8'hAA);
    check("f2_ev_valid", 32'(ev_valid), 32'd1);
    check("f2_x", 32'(x), 32'h1122);
    check("f2_y", 32'(y), 32'h3344);
    check("f2_t", 32'(t), 32'h5566);
    check("f2_p", 32'(p), 32'd0);
    check("f2_err", 32'(err_cnt), 32'd1);
    idle(1);

    // Back-pressure on the flags byte
    ev_ready = 1'b0;
    send_frame(16'h0102, 16'h0304, 16'h0506, 8'hAB);
    check("h1_ev_valid", 32'(ev_valid), 32'd1);
    check("h1_x", 32'(x), 32'h0102);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    check("h_hold_x", 32'(x), 32'h0102);
    in_data  = 8'hAB;
    in_valid = 1'b1;
    #1;
    check("h_stall_ready", 32'(in_ready), 32'd0);
    idle(2);
    check("h_stall_ready2", 32'(in_ready), 32'd0);
    check("h_stall_valid", 32'(ev_valid), 32'd1);
    check("h_stall_x", 32'(x), 32'h0102);
    check("h_stall_t", 32'(t), 32'h0506);
    ev_ready = 1'b1;
    #1;
    check("h_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("h2_ev_valid", 32'(ev_valid), 32'd1);
    check("h2_x", 32'(x), 32'hA1A2);
    check("h2_y", 32'(y), 32'hB1B2);
    check("h2_t", 32'(t), 32'hC1C2);
    check("h2_p", 32'(p), 32'd1);
    idle(1);
    check("h2_consumed", 32'(ev_valid), 32'd0);

    // Partial frame interrupted by sof
    send_byte(8'hEE, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hDE, 1'b1);
    check("sof_err", 32'(err_cnt), 32'd2);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hAB, 1'b0);
    check("sof_ev_valid", 32'(ev_valid), 32'd1);
    check("sof_x", 32'(x), 32'hDEAD);
    check("sof_y", 32'(y), 32'hBEEF);
    check("sof_t", 32'(t), 32'hCAFE);
    check("sof_err2", 32'(err_cnt), 32'd2);
    idle(1);

    // Saturation: 2 + 253 = 255, then three more stay at 255
    for (int i = 0; i < 253; i++) begin
      send_frame(16'(i), 16'h0000, 16'h0000, 8'h00);
    end
    check("sat_255", 32'(err_cnt), 32'hFF);
    for (int i = 0; i < 3; i++) begin
      send_frame(16'h0000, 16'h0000, 16'h0000, 8'hFE);
    end
    check("sat_hold", 32'(err_cnt), 32'hFF);
    check("sat_ev_valid", 32'(ev_valid), 32'd0);
    check("sat_x_kept", 32'(x), 32'hDEAD);

    // Asynchronous reset mid-frame
    send_byte(8'h77, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h77, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_err", 32'(err_cnt), 32'd0);
    check("mrst_xy", {x, y}, 32'd0);
    check("mrst_tp_valid", {14'd0, t, p, ev_valid}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    send_frame(16'h1234, 16'h5678, 16'h9ABC, 8'hAB);
    check("post_ev_valid", 32'(ev_valid), 32'd1);
    check("post_xy", {x, y}, 32'h12345678);
    check("post_t", 32'(t), 32'h9ABC);
    check("post_p", 32'(p), 32'd1);
    check("post_err", 32'(err_cnt), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
